// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard detection, forwarding select and stage sequencing for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32,
    parameter int DEBUG_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_rs,
    input  logic [ADDR_W-1:0] addr_rt,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              is_store_id,
    input  logic              wb_wen_exe,
    input  logic [ADDR_W-1:0] regw_addr_exe,
    input  logic              is_load_exe,
    input  logic              wb_wen_mem,
    input  logic [ADDR_W-1:0] regw_addr_mem,
    input  logic              mem_ren_mem,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              jump_en,
    input  logic              exc_en,
    input  logic              debug_en,
    input  logic              debug_step,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_m,
    output logic              if_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              if_rst,
    output logic              id_rst,
    output logic              exe_rst,
    output logic              mem_rst,
    output logic              wb_rst,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         lcnt_q, lcnt_d;
    logic               ret_lstall_q, ret_lstall_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic               debug_step_prev_q, debug_step_prev_d;

    logic exe_wr_ok, mem_wr_ok;
    logic exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b;
    logic ldh, step_rise, dbg_freeze, mwait_cond, eff_lstall, count_cycle;

    assign exe_wr_ok = wb_wen_exe && (regw_addr_exe != '0);
    assign mem_wr_ok = wb_wen_mem && (regw_addr_mem != '0);
    assign exe_hit_a = exe_wr_ok && (regw_addr_exe == addr_rs);
    assign exe_hit_b = exe_wr_ok && (regw_addr_exe == addr_rt);
    assign mem_hit_a = mem_wr_ok && (regw_addr_mem == addr_rs);
    assign mem_hit_b = mem_wr_ok && (regw_addr_mem == addr_rt);

    assign ldh = exe_wr_ok && is_load_exe &&
                 ((rs_used && (regw_addr_exe == addr_rs)) ||
                  (rt_used && !is_store_id && (regw_addr_exe == addr_rt)));

    assign step_rise  = debug_step && !debug_step_prev_q;
    assign dbg_freeze = (DEBUG_EN != 0) && debug_en && !step_rise;
    assign mwait_cond = mem_req && !mem_ack;
    // On the ack cycle out of MWAIT the unit behaves as the state it left.
    assign eff_lstall = (state_q == LSTALL) || ((state_q == MWAIT) && ret_lstall_q);

    assign stall_cycles = stall_cycles_q;

    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        fwd_m = 1'b0;
        if (!rst) begin
            if (mem_hit_a) fwd_a = mem_ren_mem ? 2'd3 : 2'd2;
            if (exe_hit_a) fwd_a = 2'd1;
            if (mem_hit_b) fwd_b = mem_ren_mem ? 2'd3 : 2'd2;
            if (exe_hit_b) fwd_b = 2'd1;
            fwd_m = rt_used && is_store_id && is_load_exe && exe_hit_b;
        end
    end

    always_comb begin
        if_en  = 1'b1;
        id_en  = 1'b1;
        exe_en = 1'b1;
        mem_en = 1'b1;
        wb_en  = 1'b1;
        if_rst  = 1'b0;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        wb_rst  = 1'b0;
        state_d           = state_q;
        lcnt_d            = lcnt_q;
        ret_lstall_d      = ret_lstall_q;
        stall_cycles_d    = stall_cycles_q;
        debug_step_prev_d = debug_step;
        count_cycle       = 1'b0;

        if (rst) begin
            if_rst  = 1'b1;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
            wb_rst  = 1'b1;
            state_d           = RUN;
            lcnt_d            = 4'd0;
            ret_lstall_d      = 1'b0;
            stall_cycles_d    = '0;
            debug_step_prev_d = 1'b0;
        end else if (dbg_freeze) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
        end else if (mwait_cond) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_rst = 1'b1;
            state_d     = MWAIT;
            count_cycle = 1'b1;
            if (state_q != MWAIT) ret_lstall_d = (state_q == LSTALL);
        end else if (exc_en) begin
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
            state_d = RUN;
            lcnt_d  = 4'd0;
        end else if (eff_lstall || ldh) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
            count_cycle = 1'b1;
            if (eff_lstall) begin
                lcnt_d  = lcnt_q - 4'd1;
                state_d = (lcnt_q == 4'd1) ? RUN : LSTALL;
            end else if (LOAD_LAT > 1) begin
                lcnt_d  = 4'(LOAD_LAT - 1);
                state_d = LSTALL;
            end else begin
                state_d = RUN;
            end
        end else begin
            id_rst  = jump_en;
            state_d = RUN;
        end

        if (count_cycle && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= RUN;
            lcnt_q            <= 4'd0;
            ret_lstall_q      <= 1'b0;
            stall_cycles_q    <= '0;
            debug_step_prev_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            lcnt_q            <= lcnt_d;
            ret_lstall_q      <= ret_lstall_d;
            stall_cycles_q    <= stall_cycles_d;
            debug_step_prev_q <= debug_step_prev_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl (LOAD_LAT=1 and LOAD_LAT=3/CNT_W=4 instances)
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] addr_rs, addr_rt, regw_addr_exe, regw_addr_mem;
    logic       rs_used, rt_used, is_store_id, wb_wen_exe, is_load_exe;
    logic       wb_wen_mem, mem_ren_mem, mem_req, mem_ack, jump_en, exc_en;
    logic       debug_en, debug_step;

    logic [1:0]  fwd_a1, fwd_b1, fwd_a3, fwd_b3;
    logic        fwd_m1, fwd_m3;
    logic [4:0]  en1, rs1, en3, rs3;
    logic [31:0] stall1;
    logic [3:0]  stall3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(32), .DEBUG_EN(1)) u1 (
        .clk(clk), .rst(rst), .addr_rs(addr_rs), .addr_rt(addr_rt),
        .rs_used(rs_used), .rt_used(rt_used), .is_store_id(is_store_id),
        .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe), .is_load_exe(is_load_exe),
        .wb_wen_mem(wb_wen_mem), .regw_addr_mem(regw_addr_mem), .mem_ren_mem(mem_ren_mem),
        .mem_req(mem_req), .mem_ack(mem_ack), .jump_en(jump_en), .exc_en(exc_en),
        .debug_en(debug_en), .debug_step(debug_step),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1), .fwd_m(fwd_m1),
        .if_en(en1[4]), .id_en(en1[3]), .exe_en(en1[2]), .mem_en(en1[1]), .wb_en(en1[0]),
        .if_rst(rs1[4]), .id_rst(rs1[3]), .exe_rst(rs1[2]), .mem_rst(rs1[1]), .wb_rst(rs1[0]),
        .stall_cycles(stall1)
    );

    pipe_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(4), .DEBUG_EN(1)) u3 (
        .clk(clk), .rst(rst), .addr_rs(addr_rs), .addr_rt(addr_rt),
        .rs_used(rs_used), .rt_used(rt_used), .is_store_id(is_store_id),
        .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe), .is_load_exe(is_load_exe),
        .wb_wen_mem(wb_wen_mem), .regw_addr_mem(regw_addr_mem), .mem_ren_mem(mem_ren_mem),
        .mem_req(mem_req), .mem_ack(mem_ack), .jump_en(jump_en), .exc_en(exc_en),
        .debug_en(debug_en), .debug_step(debug_step),
        .fwd_a(fwd_a3), .fwd_b(fwd_b3), .fwd_m(fwd_m3),
        .if_en(en3[4]), .id_en(en3[3]), .exe_en(en3[2]), .mem_en(en3[1]), .wb_en(en3[0]),
        .if_rst(rs3[4]), .id_rst(rs3[3]), .exe_rst(rs3[2]), .mem_rst(rs3[1]), .wb_rst(rs3[0]),
        .stall_cycles(stall3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr_rs = 5'd0; addr_rt = 5'd0; rs_used = 1'b0; rt_used = 1'b0; is_store_id = 1'b0;
        wb_wen_exe = 1'b0; regw_addr_exe = 5'd0; is_load_exe = 1'b0;
        wb_wen_mem = 1'b0; regw_addr_mem = 5'd0; mem_ren_mem = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; jump_en = 1'b0; exc_en = 1'b0;
        debug_en = 1'b0; debug_step = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // lw $2 in EXE, add $3,$2,$4 in ID
    task automatic load_use_inputs();
        wb_wen_exe = 1'b1; is_load_exe = 1'b1; regw_addr_exe = 5'd2;
        addr_rs = 5'd2; addr_rt = 5'd4; rs_used = 1'b1; rt_used = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        load_use_inputs();
        cyc(); cyc(); #1;
        total_cnt++; if (rs1 !== 5'b11111) $display("FAIL reset_rst got %b exp %b", rs1, 5'b11111); else pass_cnt++;
        total_cnt++; if (en1 !== 5'b11111) $display("FAIL reset_en got %b exp %b", en1, 5'b11111); else pass_cnt++;
        total_cnt++; if (fwd_a1 !== 2'd0 || fwd_m1 !== 1'b0) $display("FAIL reset_fwd got %0d/%0d exp 0/0", fwd_a1, fwd_m1); else pass_cnt++;
        total_cnt++; if (stall1 !== 32'd0) $display("FAIL reset_stall got %0d exp 0", stall1); else pass_cnt++;
        rst = 1'b0;
        idle();
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        load_use_inputs(); #1;
        total_cnt++; if (en1 !== 5'b00111) $display("FAIL lat1_stall_en got %b exp %b", en1, 5'b00111); else pass_cnt++;
        total_cnt++; if (rs1 !== 5'b00100) $display("FAIL lat1_stall_rst got %b exp %b", rs1, 5'b00100); else pass_cnt++;
        cyc();
        wb_wen_exe = 1'b0; is_load_exe = 1'b0; regw_addr_exe = 5'd0;
        wb_wen_mem = 1'b1; mem_ren_mem = 1'b1; regw_addr_mem = 5'd2; #1;
        total_cnt++; if (en1 !== 5'b11111) $display("FAIL lat1_resume_en got %b exp %b", en1, 5'b11111); else pass_cnt++;
        total_cnt++; if (fwd_a1 !== 2'd3) $display("FAIL lat1_fwd_a got %0d exp 3", fwd_a1); else pass_cnt++;
        total_cnt++; if (stall1 !== 32'd1) $display("FAIL lat1_stall_cnt got %0d exp 1", stall1); else pass_cnt++;
    endtask

    task automatic test_load_use_lat3();
        do_reset();
        load_use_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (en3 !== 5'b00111) $display("FAIL lat3_stall_en[%0d] got %b exp %b", i, en3, 5'b00111); else pass_cnt++;
            cyc();
        end
        wb_wen_exe = 1'b0; is_load_exe = 1'b0; regw_addr_exe = 5'd0;
        wb_wen_mem = 1'b1; mem_ren_mem = 1'b1; regw_addr_mem = 5'd2; #1;
        total_cnt++; if (en3 !== 5'b11111) $display("FAIL lat3_resume_en got %b exp %b", en3, 5'b11111); else pass_cnt++;
        total_cnt++; if (stall3 !== 4'd3) $display("FAIL lat3_stall_cnt got %0d exp 3", stall3); else pass_cnt++;
    endtask

    task automatic test_store_fwd();
        do_reset();
        wb_wen_exe = 1'b1; is_load_exe = 1'b1; regw_addr_exe = 5'd5;
        is_store_id = 1'b1; rt_used = 1'b1; addr_rt = 5'd5; rs_used = 1'b1; addr_rs = 5'd1; #1;
        total_cnt++; if (fwd_m1 !== 1'b1) $display("FAIL store_fwd_m got %b exp 1", fwd_m1); else pass_cnt++;
        total_cnt++; if (en1 !== 5'b11111) $display("FAIL store_no_stall got %b exp %b", en1, 5'b11111); else pass_cnt++;
        regw_addr_exe = 5'd0; addr_rs = 5'd0; addr_rt = 5'd0; is_store_id = 1'b0; #1;
        total_cnt++; if (en1 !== 5'b11111) $display("FAIL r0_no_stall got %b exp %b", en1, 5'b11111); else pass_cnt++;
        total_cnt++; if ({fwd_a1, fwd_b1, fwd_m1} !== 5'b0) $display("FAIL r0_no_fwd got %b exp 00000", {fwd_a1, fwd_b1, fwd_m1}); else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        load_use_inputs();
        cyc();
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (en3 !== 5'b00001) $display("FAIL mwait_en[%0d] got %b exp %b", i, en3, 5'b00001); else pass_cnt++;
            total_cnt++; if (rs3 !== 5'b00001) $display("FAIL mwait_rst[%0d] got %b exp %b", i, rs3, 5'b00001); else pass_cnt++;
            cyc();
        end
        mem_ack = 1'b1; #1;
        total_cnt++; if (en3 !== 5'b00111) $display("FAIL mwait_ack_lstall got %b exp %b", en3, 5'b00111); else pass_cnt++;
        cyc();
        mem_req = 1'b0; mem_ack = 1'b0; #1;
        total_cnt++; if (en3 !== 5'b00111) $display("FAIL mwait_last_lstall got %b exp %b", en3, 5'b00111); else pass_cnt++;
        cyc();
        idle(); #1;
        total_cnt++; if (en3 !== 5'b11111) $display("FAIL mwait_back_run got %b exp %b", en3, 5'b11111); else pass_cnt++;
        total_cnt++; if (stall3 !== 4'd7) $display("FAIL mwait_stall_cnt got %0d exp 7", stall3); else pass_cnt++;
    endtask

    task automatic test_exc_flush();
        do_reset();
        load_use_inputs();
        cyc();
        exc_en = 1'b1; jump_en = 1'b1; #1;
        total_cnt++; if (rs3 !== 5'b01110) $display("FAIL exc_rst got %b exp %b", rs3, 5'b01110); else pass_cnt++;
        total_cnt++; if (en3 !== 5'b11111) $display("FAIL exc_en got %b exp %b", en3, 5'b11111); else pass_cnt++;
        cyc();
        idle(); #1;
        total_cnt++; if ({en3, rs3} !== 10'b11111_00000) $display("FAIL exc_to_run got %b exp %b", {en3, rs3}, 10'b11111_00000); else pass_cnt++;
        total_cnt++; if (stall3 !== 4'd1) $display("FAIL exc_stall_cnt got %0d exp 1", stall3); else pass_cnt++;
        mem_req = 1'b1;
        cyc();
        rst = 1'b1; #1;
        total_cnt++; if ({en3, rs3} !== 10'b11111_11111) $display("FAIL rst_in_mwait got %b exp %b", {en3, rs3}, 10'b11111_11111); else pass_cnt++;
        cyc();
        rst = 1'b0; mem_req = 1'b0; #1;
        total_cnt++; if (stall3 !== 4'd0) $display("FAIL rst_clears_stall got %0d exp 0", stall3); else pass_cnt++;
        total_cnt++; if (en3 !== 5'b11111) $display("FAIL rst_mwait_run got %b exp %b", en3, 5'b11111); else pass_cnt++;
    endtask

    task automatic test_double_fwd();
        do_reset();
        wb_wen_exe = 1'b1; regw_addr_exe = 5'd7;
        wb_wen_mem = 1'b1; regw_addr_mem = 5'd7;
        addr_rs = 5'd7; addr_rt = 5'd7; rs_used = 1'b1; rt_used = 1'b1; #1;
        total_cnt++; if ({fwd_a1, fwd_b1} !== 4'b0101) $display("FAIL dbl_fwd got %b exp 0101", {fwd_a1, fwd_b1}); else pass_cnt++;
        wb_wen_exe = 1'b0; #1;
        total_cnt++; if ({fwd_a1, fwd_b1} !== 4'b1010) $display("FAIL mem_in_fwd got %b exp 1010", {fwd_a1, fwd_b1}); else pass_cnt++;
        mem_ren_mem = 1'b1; #1;
        total_cnt++; if ({fwd_a1, fwd_b1} !== 4'b1111) $display("FAIL mem_out_fwd got %b exp 1111", {fwd_a1, fwd_b1}); else pass_cnt++;
    endtask

    task automatic test_jump();
        do_reset();
        jump_en = 1'b1; #1;
        total_cnt++; if ({en1, rs1} !== 10'b11111_01000) $display("FAIL jump_flush got %b exp %b", {en1, rs1}, 10'b11111_01000); else pass_cnt++;
        load_use_inputs(); #1;
        total_cnt++; if ({en1, rs1} !== 10'b00111_00100) $display("FAIL jump_vs_stall got %b exp %b", {en1, rs1}, 10'b00111_00100); else pass_cnt++;
    endtask

    task automatic test_debug();
        do_reset();
        debug_en = 1'b1; mem_req = 1'b1; #1;
        total_cnt++; if (en1 !== 5'b00000) $display("FAIL dbg_freeze got %b exp 00000", en1); else pass_cnt++;
        cyc();
        total_cnt++; if (stall1 !== 32'd0) $display("FAIL dbg_no_count got %0d exp 0", stall1); else pass_cnt++;
        mem_req = 1'b0; debug_step = 1'b1; #1;
        total_cnt++; if (en1 !== 5'b11111) $display("FAIL dbg_step got %b exp 11111", en1); else pass_cnt++;
        cyc();
        total_cnt++; if (en1 !== 5'b00000) $display("FAIL dbg_step_held got %b exp 00000", en1); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        total_cnt++; if (stall3 !== 4'd15) $display("FAIL sat_reach got %0d exp 15", stall3); else pass_cnt++;
        for (int i = 0; i < 5; i++) cyc();
        total_cnt++; if (stall3 !== 4'd15) $display("FAIL sat_hold got %0d exp 15", stall3); else pass_cnt++;
        total_cnt++; if (stall1 !== 32'd20) $display("FAIL wide_count got %0d exp 20", stall1); else pass_cnt++;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        test_reset();
        test_load_use_lat1();
        test_load_use_lat3();
        test_store_fwd();
        test_mem_wait();
        test_exc_flush();
        test_double_fwd();
        test_jump();
        test_debug();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
